// File: rtl/load_buffer_scheduler_pkg.sv
// Shared sizing, entry/FSM encodings and helpers for the LSU load buffer scheduler.
package load_buffer_scheduler_pkg;

  localparam int LDB_NUM   = 16;
  localparam int LDB_WIDTH = $clog2(LDB_NUM);
  localparam int XLEN      = 32;
  localparam int TAG_W     = 6;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    ISSUED,
    DONE
  } ldb_state_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DRAIN
  } ldb_fsm_t;

  typedef struct packed {
    ldb_state_t             state;
    logic [XLEN-1:0]        addr;
    logic [TAG_W-1:0]       tag;
    logic [XLEN-1:0]        data;
  } ldb_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ldb_oldest_select.sv
// Picks the oldest candidate entry using the age matrix (row i bit j set = j older than i).
module ldb_oldest_select #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0]        i_cand,
  input  logic [N-1:0][N-1:0] i_age,
  output logic [N-1:0]        o_onehot,
  output logic [W-1:0]        o_index,
  output logic                o_valid
);

  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    // An entry is oldest when no other candidate is marked older than it.
    for (int i = 0; i < N; i++) begin
      if (i_cand[i] && ((i_age[i] & i_cand) == '0)) begin
        o_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (o_onehot[i]) begin
        o_index = W'(i);
      end
    end
  end

  assign o_valid = |i_cand;

endmodule

// File: rtl/load_buffer_scheduler.sv
// LSU load buffer: allocation, oldest-first single-outstanding D-cache issue, oldest-first CDB writeback.
// Optional LDB_PERF_CNT_EN adds saturating full-stall and issue-wait cycle counters.
module load_buffer_scheduler
  import load_buffer_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [XLEN-1:0]      alloc_addr_i,
  input  logic [TAG_W-1:0]     alloc_tag_i,
  output logic [LDB_WIDTH-1:0] alloc_index_o,
  output logic                 mem_req_o,
  output logic [XLEN-1:0]      mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rsp_valid_i,
  input  logic [XLEN-1:0]      mem_rsp_data_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [TAG_W-1:0]     wb_tag_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic [LDB_WIDTH:0]   occupancy_o
`ifdef LDB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_full_cycles_o,
  output logic [31:0]          perf_issue_wait_o
`endif
);

  localparam int OCC_W = LDB_WIDTH + 1;

  ldb_entry_t                      r_ent [LDB_NUM];
  ldb_state_t                      w_state_nxt [LDB_NUM];
  logic [LDB_NUM-1:0][LDB_NUM-1:0] r_age;

  ldb_fsm_t                        r_fsm;
  ldb_fsm_t                        w_fsm_nxt;
  logic [LDB_NUM-1:0]              r_issue_oh;
  logic [XLEN-1:0]                 r_mem_addr;

  logic                            r_wb_valid;
  logic [LDB_NUM-1:0]              r_wb_oh;
  logic [TAG_W-1:0]                r_wb_tag;
  logic [XLEN-1:0]                 r_wb_data;
  logic [OCC_W-1:0]                r_occ;
  logic [OCC_W-1:0]                w_occ_nxt;

  logic [LDB_NUM-1:0]              w_free;
  logic [LDB_NUM-1:0]              w_wait;
  logic [LDB_NUM-1:0]              w_done;
  logic [LDB_WIDTH-1:0]            w_alloc_idx;
  logic                            w_alloc;

  logic [LDB_NUM-1:0]              w_issue_oh;
  logic [LDB_WIDTH-1:0]            w_issue_idx;
  logic                            w_issue_vld;
  logic                            w_issue_start;
  logic                            w_ack_fire;
  logic                            w_rsp_fire;

  logic [LDB_NUM-1:0]              w_wb_cand;
  logic [LDB_NUM-1:0]              w_wb_oh;
  logic [LDB_WIDTH-1:0]            w_wb_idx;
  logic                            w_wb_vld;
  logic                            w_wb_hs;

  always_comb begin
    w_free = '0;
    w_wait = '0;
    w_done = '0;
    for (int i = 0; i < LDB_NUM; i++) begin
      w_free[i] = (r_ent[i].state == FREE);
      w_wait[i] = (r_ent[i].state == WAIT);
      w_done[i] = (r_ent[i].state == DONE);
    end
  end

  always_comb begin
    w_alloc_idx = '0;
    for (int i = LDB_NUM - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_idx = LDB_WIDTH'(i);
      end
    end
  end

  assign alloc_ready_o = |w_free;
  assign alloc_index_o = w_alloc_idx;
  assign w_alloc       = alloc_valid_i & alloc_ready_o & ~flush_i;

  ldb_oldest_select #(
    .N (LDB_NUM),
    .W (LDB_WIDTH)
  ) u_issue_sel (
    .i_cand   (w_wait),
    .i_age    (r_age),
    .o_onehot (w_issue_oh),
    .o_index  (w_issue_idx),
    .o_valid  (w_issue_vld)
  );

  // The entry handed to the CDB this cycle is excluded so its successor can follow immediately.
  assign w_wb_hs   = r_wb_valid & wb_ready_i;
  assign w_wb_cand = w_done & ~(w_wb_hs ? r_wb_oh : '0);

  ldb_oldest_select #(
    .N (LDB_NUM),
    .W (LDB_WIDTH)
  ) u_wb_sel (
    .i_cand   (w_wb_cand),
    .i_age    (r_age),
    .o_onehot (w_wb_oh),
    .o_index  (w_wb_idx),
    .o_valid  (w_wb_vld)
  );

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_issue_start = 1'b0;
    w_ack_fire    = 1'b0;
    w_rsp_fire    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (!flush_i && w_issue_vld) begin
          w_fsm_nxt     = REQ;
          w_issue_start = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (flush_i) begin
            w_fsm_nxt = DRAIN;
          end else begin
            w_fsm_nxt  = RSP;
            w_ack_fire = 1'b1;
          end
        end else if (flush_i) begin
          w_fsm_nxt = IDLE;
        end
      end
      RSP: begin
        if (mem_rsp_valid_i) begin
          w_fsm_nxt  = IDLE;
          w_rsp_fire = ~flush_i;
        end else if (flush_i) begin
          w_fsm_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rsp_valid_i) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue_oh <= '0;
      r_mem_addr <= '0;
    end else if (w_issue_start) begin
      r_issue_oh <= w_issue_oh;
      r_mem_addr <= r_ent[w_issue_idx].addr;
    end
  end

  always_comb begin
    for (int i = 0; i < LDB_NUM; i++) begin
      w_state_nxt[i] = r_ent[i].state;
      if (flush_i) begin
        w_state_nxt[i] = FREE;
      end else begin
        if (w_alloc && (w_alloc_idx == LDB_WIDTH'(i))) w_state_nxt[i] = WAIT;
        if (w_ack_fire && r_issue_oh[i])               w_state_nxt[i] = ISSUED;
        if (w_rsp_fire && r_issue_oh[i])               w_state_nxt[i] = DONE;
        if (w_wb_hs && r_wb_oh[i])                     w_state_nxt[i] = FREE;
      end
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < LDB_NUM; i++) begin
      if (w_state_nxt[i] != FREE) begin
        w_occ_nxt = w_occ_nxt + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LDB_NUM; i++) begin
      if (!rst_n) begin
        r_ent[i].state <= FREE;
      end else begin
        r_ent[i].state <= w_state_nxt[i];
      end
      if (w_alloc && (w_alloc_idx == LDB_WIDTH'(i))) begin
        r_ent[i].addr <= alloc_addr_i;
        r_ent[i].tag  <= alloc_tag_i;
      end
      if (w_rsp_fire && r_issue_oh[i]) begin
        r_ent[i].data <= mem_rsp_data_i;
      end
    end
  end

  // A new entry is younger than everything live; stale bits toward freed slots are masked by the candidate sets.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_age <= '0;
    end else if (w_alloc) begin
      for (int k = 0; k < LDB_NUM; k++) begin
        if (w_alloc_idx == LDB_WIDTH'(k)) begin
          r_age[k] <= ~w_free;
        end else begin
          r_age[k][w_alloc_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_oh    <= '0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
    end else if (flush_i) begin
      r_wb_valid <= 1'b0;
    end else if (!r_wb_valid || wb_ready_i) begin
      r_wb_valid <= w_wb_vld;
      if (w_wb_vld) begin
        r_wb_oh   <= w_wb_oh;
        r_wb_tag  <= r_ent[w_wb_idx].tag;
        r_wb_data <= r_ent[w_wb_idx].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

`ifdef LDB_PERF_CNT_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_full <= '0;
      r_perf_wait <= '0;
    end else begin
      if (alloc_valid_i && !alloc_ready_o) r_perf_full <= sat_inc32(r_perf_full);
      if ((r_fsm == REQ) && !mem_ack_i)    r_perf_wait <= sat_inc32(r_perf_wait);
    end
  end

  assign perf_full_cycles_o = r_perf_full;
  assign perf_issue_wait_o  = r_perf_wait;
`endif

  assign mem_req_o   = (r_fsm == REQ);
  assign mem_addr_o  = r_mem_addr;
  assign wb_valid_o  = r_wb_valid;
  assign wb_tag_o    = r_wb_tag;
  assign wb_data_o   = r_wb_data;
  assign occupancy_o = r_occ;

endmodule

// File: tb/tb_load_buffer_scheduler.sv
// Directed self-checking bench for load_buffer_scheduler.
module tb_load_buffer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] alloc_addr_i;
  logic [5:0]  alloc_tag_i;
  logic [3:0]  alloc_index_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [5:0]  wb_tag_o;
  logic [31:0] wb_data_o;
  logic [4:0]  occupancy_o;
`ifdef LDB_PERF_CNT_EN
  logic [31:0] perf_full_cycles_o;
  logic [31:0] perf_issue_wait_o;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  load_buffer_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_ready_o   (alloc_ready_o),
    .alloc_addr_i    (alloc_addr_i),
    .alloc_tag_i     (alloc_tag_i),
    .alloc_index_o   (alloc_index_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_tag_o        (wb_tag_o),
    .wb_data_o       (wb_data_o),
    .occupancy_o     (occupancy_o)
`ifdef LDB_PERF_CNT_EN
    ,
    .perf_full_cycles_o (perf_full_cycles_o),
    .perf_issue_wait_o  (perf_issue_wait_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    flush_i         = 1'b0;
    alloc_valid_i   = 1'b0;
    alloc_addr_i    = 32'd0;
    alloc_tag_i     = 6'd0;
    mem_ack_i       = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = 32'd0;
    wb_ready_i      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [5:0] t, input logic [3:0] idx);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
    alloc_tag_i   = t;
    chk("alloc_ready", 64'(alloc_ready_o), 64'd1);
    chk("alloc_index", 64'(alloc_index_o), 64'(idx));
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!mem_req_o && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", 64'(mem_req_o), 64'd1);
    chk("mem_addr", 64'(mem_addr_o), 64'(a));
  endtask

  task automatic respond(input logic [31:0] d);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("mem_req_drop_after_ack", 64'(mem_req_o), 64'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    tick();
    mem_rsp_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input logic [5:0] t, input logic [31:0] d);
    int n = 0;
    while (!wb_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("wb_valid_seen", 64'(wb_valid_o), 64'd1);
    chk("wb_tag", 64'(wb_tag_o), 64'(t));
    chk("wb_data", 64'(wb_data_o), 64'(d));
  endtask

  task automatic handshake();
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wb_tag", 64'(wb_tag_o), 64'd0);
    chk("rst_wb_data", 64'(wb_data_o), 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    rst_n = 1'b1;

    // Single load round trip with a two-cycle ack delay
    alloc(32'h100, 6'd5, 4'd0);
    chk("t1_occ_after_alloc", 64'(occupancy_o), 64'd1);
    wait_req(32'h100);
    tick();
    chk("t1_req_hold", 64'(mem_req_o), 64'd1);
    chk("t1_addr_hold", 64'(mem_addr_o), 64'h100);
    tick();
    chk("t1_req_hold2", 64'(mem_req_o), 64'd1);
    respond(32'hDEADBEEF);
    wait_wb(6'd5, 32'hDEADBEEF);
    handshake();
    chk("t1_wb_valid_clear", 64'(wb_valid_o), 64'd0);
    chk("t1_occ_empty", 64'(occupancy_o), 64'd0);

    // Fill all 16 entries, overflow is dropped, freed slot 3 is reused
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(32'h1000 + 32'(4 * i), 6'(8 + i), 4'(i));
    end
    chk("t2_full_ready", 64'(alloc_ready_o), 64'd0);
    chk("t2_full_occ", 64'(occupancy_o), 64'd16);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = 32'hBAD;
    alloc_tag_i   = 6'd63;
    repeat (10) tick();
    alloc_valid_i = 1'b0;
    chk("t2_overflow_occ", 64'(occupancy_o), 64'd16);
    chk("t2_overflow_ready", 64'(alloc_ready_o), 64'd0);
`ifdef LDB_PERF_CNT_EN
    chk("t2_perf_full", 64'(perf_full_cycles_o), 64'd10);
`endif
    for (int k = 0; k < 3; k++) begin
      wait_req(32'h1000 + 32'(4 * k));
      respond(32'h50 + 32'(k));
      wait_wb(6'(8 + k), 32'h50 + 32'(k));
      chk("t2_full_before_wb", 64'(alloc_ready_o), 64'd0);
      handshake();
      alloc(32'h2000 + 32'(4 * k), 6'(40 + k), 4'(k));
    end
    wait_req(32'h100C);
    respond(32'h53);
    wait_wb(6'd11, 32'h53);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = 32'h3000;
    alloc_tag_i   = 6'd50;
    chk("t2_no_reuse_same_cycle", 64'(alloc_ready_o), 64'd0);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("t2_reuse_ready", 64'(alloc_ready_o), 64'd1);
    chk("t2_reuse_index", 64'(alloc_index_o), 64'd3);
    tick();
    alloc_valid_i = 1'b0;
    chk("t2_refull_occ", 64'(occupancy_o), 64'd16);

    // Issue order follows age, not index
    do_reset();
    alloc(32'h310, 6'd1, 4'd0);
    alloc(32'h320, 6'd2, 4'd1);
    alloc(32'h330, 6'd3, 4'd2);
    wait_req(32'h310);
    respond(32'h11);
    wait_wb(6'd1, 32'h11);
    handshake();
    alloc(32'h340, 6'd4, 4'd0);
    for (int t = 2; t <= 4; t++) begin
      wait_req(32'h300 + 32'(16 * t));
      respond(32'hA0 + 32'(t));
      wait_wb(6'(t), 32'hA0 + 32'(t));
      handshake();
    end
    chk("t3_occ_empty", 64'(occupancy_o), 64'd0);

    // Writeback back-pressure with two completed loads
    do_reset();
    alloc(32'h400, 6'd10, 4'd0);
    alloc(32'h404, 6'd11, 4'd1);
    wait_req(32'h400);
    respond(32'h0A0A);
    wait_req(32'h404);
    respond(32'h0B0B);
    wait_wb(6'd10, 32'h0A0A);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", 64'(wb_valid_o), 64'd1);
      chk("t4_hold_tag", 64'(wb_tag_o), 64'd10);
      chk("t4_hold_data", 64'(wb_data_o), 64'h0A0A);
    end
    wb_ready_i = 1'b1;
    tick();
    chk("t4_next_valid", 64'(wb_valid_o), 64'd1);
    chk("t4_next_tag", 64'(wb_tag_o), 64'd11);
    chk("t4_next_data", 64'(wb_data_o), 64'h0B0B);
    tick();
    wb_ready_i = 1'b0;
    chk("t4_drained_valid", 64'(wb_valid_o), 64'd0);
    chk("t4_drained_occ", 64'(occupancy_o), 64'd0);

    // Flush with a response outstanding; the stale response must be dropped
    do_reset();
    alloc(32'h500, 6'd20, 4'd0);
    alloc(32'h504, 6'd21, 4'd1);
    alloc(32'h508, 6'd22, 4'd2);
    wait_req(32'h500);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i     = 1'b0;
    flush_i       = 1'b1;
    alloc_valid_i = 1'b1;
    alloc_addr_i  = 32'h777;
    alloc_tag_i   = 6'd63;
    tick();
    flush_i       = 1'b0;
    alloc_valid_i = 1'b0;
    chk("t5_flush_occ", 64'(occupancy_o), 64'd0);
    chk("t5_flush_ready", 64'(alloc_ready_o), 64'd1);
    chk("t5_flush_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("t5_flush_mem_req", 64'(mem_req_o), 64'd0);
    alloc(32'h600, 6'd30, 4'd0);
    chk("t5_drain_alloc_occ", 64'(occupancy_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_drain_blocks_issue", 64'(mem_req_o), 64'd0);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h1234;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("t5_discard_wb_valid", 64'(wb_valid_o), 64'd0);
    wait_req(32'h600);
    respond(32'hCAFEF00D);
    wait_wb(6'd30, 32'hCAFEF00D);
    handshake();
    chk("t5_final_occ", 64'(occupancy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
